// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, flag positions,
// output-register state encodings and the registered response layout.
package alu_share_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
    logic             illegal;
  } alu_rsp_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester/consumer bundle for alu_share_arbiter. The perf counter outputs
// exist only when ALU_SHARE_PERF_EN is defined.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*3-1:0]  req_op;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [3:0]            rsp_flags;
  logic                  rsp_illegal;
  logic                  busy;

`ifdef ALU_SHARE_PERF_EN
  logic [NUM_REQ*16-1:0] perf_grants;
  logic [15:0]           perf_stall;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal,
           busy, perf_grants, perf_stall
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal,
           busy, perf_grants, perf_stall
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal, busy
  );
`endif

endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: ADD, SUB, AND, OR, SLT with {Z,N,V,C}.
// Undefined op codes return 0 (so Z=1) with V=C=0.
module alu
  import alu_share_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op,
  output logic [ALU_W-1:0] result,
  output logic [3:0]       flags
);

  logic [ALU_W:0] sum;
  logic           v;
  logic           c;

  always_comb begin
    sum    = '0;
    result = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[ALU_W-1:0];
        c      = sum[ALU_W];
        v      = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        // Carry is the carry-out of a + ~b + 1, i.e. 1 when no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        result = sum[ALU_W-1:0];
        c      = sum[ALU_W];
        v      = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[ALU_W-1];
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: first request at or after ptr wins, wrapping
// to index 0. Produces a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a value unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment [ptr, NUM_REQ-1] has priority over the wrapped [0, ptr-1].
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && en && req[i] && (ID_W'(i) >= ptr)) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        any      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && en && req[i] && (ID_W'(i) < ptr)) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant and a single
// registered response slot. Define ALU_SHARE_PERF_EN to add perf counters.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  logic [0:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_next;
  logic               can_accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               xfer;

  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [2:0]         alu_op;
  logic [ALU_W-1:0]   alu_result;
  logic [3:0]         alu_flags;

  alu_rsp_t           rsp_q;
  logic [ID_W-1:0]    rsp_id_q;

  // A new result may be captured when the slot is empty or drains this cycle.
  assign can_accept = (state == ST_EMPTY) || bus.rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (can_accept && !rst),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (xfer)
  );

  assign bus.req_ready = grant;

  assign alu_a  = bus.req_a [XLEN*int'(gnt_idx) +: XLEN];
  assign alu_b  = bus.req_b [XLEN*int'(gnt_idx) +: XLEN];
  assign alu_op = bus.req_op[3*int'(gnt_idx)    +: 3];

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      ptr      <= '0;
      rsp_q    <= '0;
      rsp_id_q <= '0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state    <= ST_FULL;
      ptr      <= ptr_next;
      rsp_q    <= '{result: alu_result, flags: alu_flags, illegal: !op_is_legal(alu_op)};
      rsp_id_q <= gnt_idx;
    end else if (bus.rsp_ready) begin
      state    <= ST_EMPTY;
    end
  end

  assign bus.rsp_valid   = (state == ST_FULL);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_q.result;
  assign bus.rsp_flags   = rsp_q.flags;
  assign bus.rsp_illegal = rsp_q.illegal;
  assign bus.busy        = bus.rsp_valid && !bus.rsp_ready;

`ifdef ALU_SHARE_PERF_EN
  logic [15:0] stall_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_grant
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (grant[g] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end

    assign bus.perf_grants[16*g +: 16] = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.busy && (|bus.req_valid) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.perf_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (3 requesters): directed steps
// followed by constrained-random traffic against a behavioural model.
module tb_alu_share_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  alu_share_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IW),
    .XLEN    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus state
  logic        tv [N];
  logic [31:0] ta [N];
  logic [31:0] tb [N];
  logic [2:0]  top [N];
  logic        trr;

  // Reference model state
  int          ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  bit          m_ill;
  int          last_win;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = tv[i];
      bus.req_a[32*i +: 32]   = ta[i];
      bus.req_b[32*i +: 32]   = tb[i];
      bus.req_op[3*i +: 3]    = top[i];
    end
    bus.rsp_ready = trr;
  endtask

  // ALU behaviour computed with wide signed arithmetic.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, output logic [31:0] r,
                                  output logic [3:0] f, output bit ill);
    longint sa;
    longint sb;
    longint wide;
    logic [32:0] u;
    bit v;
    bit c;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    v   = 1'b0;
    c   = 1'b0;
    ill = 1'b0;
    r   = '0;
    case (op)
      3'd0: begin
        u    = {1'b0, a} + {1'b0, b};
        r    = u[31:0];
        c    = u[32];
        wide = sa + sb;
        v    = (wide != longint'($signed(r)));
      end
      3'd1: begin
        r    = a - b;
        c    = (a >= b);
        wide = sa - sb;
        v    = (wide != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    f = {(r == 32'd0), r[31], v, c};
  endfunction

  function automatic int pick();
    if (rst) return -1;
    if (m_valid && !trr) return -1;
    for (int k = 0; k < N; k++) begin
      if (tv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr      = 0;
    m_valid  = 1'b0;
    m_id     = 0;
    m_res    = '0;
    m_flags  = '0;
    m_ill    = 1'b0;
    last_win = -1;
  endtask

  // Called at a negedge with stimulus arrays prepared; returns at the next negedge.
  task automatic run_cycle();
    logic [N-1:0] er;
    int w;
    apply();
    #1;
    w  = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("busy", 64'(bus.busy), 64'(m_valid && !trr));
    @(posedge clk);
    if (w >= 0) begin
      ref_alu(ta[w], tb[w], top[w], m_res, m_flags, m_ill);
      m_valid = 1'b1;
      m_id    = w;
      ptr     = (w + 1) % N;
    end else if (trr) begin
      m_valid = 1'b0;
    end
    last_win = w;
    @(negedge clk);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      chk("rsp_result", 64'(bus.rsp_result), 64'(m_res));
      chk("rsp_flags", 64'(bus.rsp_flags), 64'(m_flags));
      chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(m_ill));
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      tv[i] = 1'b0; ta[i] = '0; tb[i] = '0; top[i] = '0;
    end
    trr = 1'b1;
    model_reset();

    // Reset: outputs zero, and no grant even with a request pending.
    rst   = 1'b1;
    tv[0] = 1'b1;
    apply();
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // req0: 5 + 3
    ta[0] = 32'd5; tb[0] = 32'd3; top[0] = 3'b000;
    run_cycle();
    chk("add_result", 64'(bus.rsp_result), 64'd8);
    chk("add_flags", 64'(bus.rsp_flags), 64'h0);
    chk("add_id", 64'(bus.rsp_id), 64'd0);
    tv[0] = 1'b0;

    // req1: 3 - 5, then SLT with the same operands
    tv[1] = 1'b1; ta[1] = 32'd3; tb[1] = 32'd5; top[1] = 3'b001;
    run_cycle();
    chk("sub_result", 64'(bus.rsp_result), 64'hFFFF_FFFE);
    chk("sub_flags", 64'(bus.rsp_flags), 64'b0100);
    chk("sub_id", 64'(bus.rsp_id), 64'd1);
    top[1] = 3'b101;
    run_cycle();
    chk("slt_result", 64'(bus.rsp_result), 64'd1);
    tv[1] = 1'b0;
    run_cycle();

    // Both requesters continuously valid: alternate 0,1,0,1 with no bubbles.
    tv[0] = 1'b1; tv[1] = 1'b1;
    ta[0] = 32'd10; tb[0] = 32'd20; top[0] = 3'b010;
    ta[1] = 32'd7;  tb[1] = 32'd9;  top[1] = 3'b011;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      chk("alt_winner", 64'(last_win), 64'(k % 2));
      chk("alt_valid", 64'(bus.rsp_valid), 64'd1);
    end

    // Output stalled for 3 cycles: held contents, no grant, busy.
    trr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      chk("stall_busy", 64'(bus.busy), 64'd1);
      chk("stall_id", 64'(bus.rsp_id), 64'd1);
    end
    trr = 1'b1;
    run_cycle();
    chk("release_winner", 64'(last_win), 64'd0);
    tv[0] = 1'b0; tv[1] = 1'b0;
    run_cycle();

    // Overflow on ADD, then an illegal op from requester 2.
    tv[2] = 1'b1; ta[2] = 32'h7FFF_FFFF; tb[2] = 32'd1; top[2] = 3'b000;
    run_cycle();
    chk("ovf_result", 64'(bus.rsp_result), 64'h8000_0000);
    chk("ovf_flags", 64'(bus.rsp_flags), 64'b0110);
    top[2] = 3'b110;
    run_cycle();
    chk("ill_result", 64'(bus.rsp_result), 64'd0);
    chk("ill_flags", 64'(bus.rsp_flags), 64'b1000);
    chk("ill_flag", 64'(bus.rsp_illegal), 64'd1);
    tv[2] = 1'b0;

    // Reset while FULL with a request pending: outputs clear without a clock edge.
    tv[1] = 1'b1; ta[1] = 32'd1; tb[1] = 32'd1; top[1] = 3'b000;
    run_cycle();
    trr = 1'b0; tv[0] = 1'b1;
    apply();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("arst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("arst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("arst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    trr = 1'b1;
    run_cycle();
    chk("post_rst_winner", 64'(last_win), 64'd0);

    // Random traffic; a requester holds its request until it is granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(tv[i] && (last_win != i))) begin
          tv[i]  = ($urandom_range(0, 3) != 0);
          ta[i]  = rand_operand();
          tb[i]  = rand_operand();
          top[i] = 3'($urandom_range(0, 7));
        end
      end
      trr = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
